// File: rtl/processador_pkg.sv
// Shared definitions for the processor control units: opcodes and the
// memory-control state encoding.
package processador_pkg;

  localparam logic [3:0] OP_STORE   = 4'b1100;
  localparam logic [3:0] OP_LOADLED = 4'b1101;
  localparam logic [3:0] OP_LOADA   = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_DONE
  } estado_t;

  function automatic logic eh_acesso_mem(input logic [3:0] op);
    return (op == OP_STORE) || (op == OP_LOADLED) || (op == OP_LOADA);
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Loadable down-counter with clear and enable; expirou flags terminal count.
module contador_timeout #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] valor,
  output logic         expirou
);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
    end else if (clear) begin
      contagem <= '0;
    end else if (load) begin
      contagem <= valor;
    end else if (enable && (contagem != '0)) begin
      contagem <= contagem - 1'b1;
    end
  end

  assign expirou = (contagem == '0);

endmodule

// File: rtl/unidade_controle_mem.sv
// Memory-side control unit: accepts an instruction, runs one handshaked RAM
// access with optional timeout, and routes read data to the LEDs or register A.
//
// state   | meaning
// IDLE    | instr_ready high, waiting for instr_valid
// MEM     | mem_req held until mem_ack or timeout
// DONE    | one-cycle done (and variacao on a good LOADA)
module unidade_controle_mem #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] operando,
  input  logic [DATA_W-1:0] regSaidaULA,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] dataInMem,
  input  logic [DATA_W-1:0] dataOutMem,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ledSaidaMem,
  output logic [DATA_W-1:0] reg_a_data,
  output logic              variacao,
  output logic              done,
  output logic              erro
);

  import processador_pkg::*;

  estado_t    estado;
  logic [3:0] op_q;
  logic       aceita;
  logic       expirou;

  assign aceita = (estado == ST_IDLE) && instr_ready && instr_valid;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      // Loaded with TIMEOUT-1 so terminal count lands in the last allowed MEM cycle.
      contador_timeout #(.W(CNT_W)) u_contador (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (estado == ST_DONE),
        .load    (aceita),
        .enable  (estado == ST_MEM),
        .valor   (CNT_W'(TIMEOUT - 1)),
        .expirou (expirou)
      );
    end else begin : g_sem_timeout
      assign expirou = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= ST_IDLE;
      op_q        <= '0;
      instr_ready <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      dataInMem   <= '0;
      ledSaidaMem <= '0;
      reg_a_data  <= '0;
      variacao    <= 1'b0;
      done        <= 1'b0;
      erro        <= 1'b0;
    end else begin
      done     <= 1'b0;
      variacao <= 1'b0;
      case (estado)
        ST_IDLE: begin
          if (aceita) begin
            instr_ready <= 1'b0;
            op_q        <= opcode;
            mem_addr    <= operando;
            dataInMem   <= regSaidaULA;
            erro        <= 1'b0;
            if (eh_acesso_mem(opcode)) begin
              mem_req <= 1'b1;
              mem_we  <= (opcode == OP_STORE);
              estado  <= ST_MEM;
            end else begin
              done   <= 1'b1;
              estado <= ST_DONE;
            end
          end else begin
            instr_ready <= 1'b1;
          end
        end
        ST_MEM: begin
          // Ack is checked first so an ack on the terminal-count cycle still succeeds.
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            estado  <= ST_DONE;
            if (op_q == OP_LOADLED) begin
              ledSaidaMem <= dataOutMem;
            end else if (op_q == OP_LOADA) begin
              reg_a_data <= dataOutMem;
              variacao   <= 1'b1;
            end
          end else if (expirou) begin
            mem_req <= 1'b0;
            erro    <= 1'b1;
            done    <= 1'b1;
            estado  <= ST_DONE;
          end
        end
        ST_DONE: begin
          instr_ready <= 1'b1;
          estado      <= ST_IDLE;
        end
        default: begin
          estado <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/unidade_controle_mem.md
# unidade_controle_mem

Parametrised memory-side control unit for the simple processor. Decodes the 4-bit opcode, runs a handshaked, wait-state-tolerant access to data RAM, and routes results to the LED output register or to register A. It sits between the instruction fetch/decode stage, the ULA output register and the RAM. It adds a valid/ready instruction handshake, a variable-latency memory ack, a bounded timeout with an error flag, and one-cycle completion strobes.

## Interface
Parameters:
- DATA_W, 8, width of the data path (ULA result, RAM data, LED and register A data)
- ADDR_W, 4, width of operando, which is used directly as the RAM address
- TIMEOUT, 15, maximum cycles to wait for mem_ack; 0 disables the timeout

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  opcode/operando are valid
- instr_ready  out  1  unit can accept an instruction
- opcode  in  4  instruction opcode
- operando  in  ADDR_W  RAM address
- regSaidaULA  in  DATA_W  ULA output register
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  out  ADDR_W  access address
- dataInMem  out  DATA_W  write data
- dataOutMem  in  DATA_W  read data, valid in the cycle mem_ack is high
- mem_ack  in  1  access complete
- ledSaidaMem  out  DATA_W  LED display register
- reg_a_data  out  DATA_W  data for register A
- variacao  out  1  one-cycle strobe: register A must load reg_a_data
- done  out  1  one-cycle strobe: instruction retired
- erro  out  1  sticky timeout flag

## Operation
Opcodes:
- 1100 STORE: mem[operando] <= regSaidaULA.
- 1101 LOADLED: ledSaidaMem <= mem[operando].
- 1110 LOADA: reg_a_data <= mem[operando], and variacao pulses.
- Any other opcode is a NOP. It is accepted, retires with done, and makes no memory access.

States: IDLE, MEM, DONE.
- IDLE: instr_ready = 1. On instr_valid, latch opcode, operando and regSaidaULA (the snapshot is taken at acceptance), and clear erro. A memory opcode goes to MEM; a NOP goes to DONE.
- MEM: mem_req = 1. mem_we, mem_addr and dataInMem come from the latched values and stay stable until exit.
  - On mem_ack for a read, capture dataOutMem into ledSaidaMem (1101) or into reg_a_data (1110), then go to DONE.
  - On mem_ack for a write, go to DONE.
- Timeout: a wait counter (width clog2(TIMEOUT+1)) counts cycles spent in MEM. If it reaches TIMEOUT with no ack:
  - mem_req drops, erro sets, and the state goes to DONE;
  - no destination register is updated;
  - variacao is suppressed.
- DONE: done = 1 for one cycle, plus variacao = 1 if this was a successful 1110. Return to IDLE.
- mem_ack outside MEM is ignored.
- ledSaidaMem and reg_a_data hold their values between loads.

## Timing
- Reset (async assert, sync release): state = IDLE; every output = 0, including ledSaidaMem, reg_a_data and erro. instr_ready rises in the first cycle after reset release.
- Assertion of reset_n low mid-access drops mem_req immediately. The in-flight instruction is lost and no done is issued.
- Acceptance happens in cycle N. mem_req is high from N+1. An ack sampled in cycle N+k gives done in N+k+1. Minimum latency is 2 cycles (ack in N+1); NOP latency is 1 cycle.
- A timeout with TIMEOUT = T gives mem_req high for exactly T cycles (N+1..N+T) and done plus erro in N+T+1.
- An ack arriving in the same cycle the counter hits T counts as success: ack wins.
- instr_ready is low in MEM and DONE. A new instruction can be accepted in the cycle after done, so peak throughput is one instruction per 3 cycles.
- erro stays high until the next accepted instruction.

## Structure
- Shared package (`processador_pkg`):
  - opcode constants OP_STORE = 4'b1100, OP_LOADLED = 4'b1101, OP_LOADA = 4'b1110;
  - the state enum.
- Sub-module `contador_timeout`: a loadable down-counter with clear, enable and an `expirou` output. Instantiate it only when TIMEOUT > 0.
- Everything else is a single always block for the FSM plus registered outputs.

## Test plan
- Reset with all inputs at X, then release: all outputs are 0, and instr_ready = 1 one cycle after release.
- STORE: opcode 1100, operando 4'h3, regSaidaULA 8'hA5, ack after 2 wait cycles. Required:
  - mem_req, mem_we, mem_addr = 3 and dataInMem = A5 held stable for 3 cycles;
  - done one cycle after ack;
  - regSaidaULA changed to 00 after acceptance leaves dataInMem at A5.
- LOADA: opcode 1110, operando 4'h7, dataOutMem = 8'h3C with ack at N+1. Required: reg_a_data = 3C, and variacao and done high together at N+2 for one cycle.
- LOADLED timeout: TIMEOUT = 4, no ack. Required:
  - mem_req high exactly 4 cycles;
  - done and erro at N+5;
  - ledSaidaMem unchanged and variacao stays 0;
  - the next accepted instruction clears erro.
- Ack on the timeout boundary: ack arrives in the 4th MEM cycle with TIMEOUT = 4. Required: treated as success and erro stays 0.
- NOP 0000 with a stray mem_ack in IDLE: done at N+1, and mem_req never asserts. Then assert reset_n low mid-MEM: mem_req falls asynchronously and no done follows.
